// File: rtl/dfp_rx_if.sv
// Result bus of the DFPlayer response receiver.
// It carries the serial line in and the decoded frame and status out.
// master: the receiver. slave: the consumer, which also owns the serial line.
interface dfp_rx_if;
  logic        uart_rxd;
  logic        rx_valid;
  logic [7:0]  rx_cmd;
  logic [15:0] rx_param;
  logic        play_done;
  logic        err_cksum;
  logic        err_frame;
  logic        busy;

  modport master (
    input  uart_rxd,
    output rx_valid, rx_cmd, rx_param, play_done, err_cksum, err_frame, busy
  );

  modport slave (
    output uart_rxd,
    input  rx_valid, rx_cmd, rx_param, play_done, err_cksum, err_frame, busy
  );
endinterface

// File: rtl/dfp_rx.sv
// DFPlayer-Mini response receiver.
// An 8N1 UART deserialiser feeds a frame parser for 7E FF 06 CMD FBK P1 P2 CKH CKL EF.
// Good frames update rx_cmd/rx_param and pulse rx_valid. Track-finished commands
// (0x3C/0x3D) also pulse play_done. Bad frames pulse err_cksum or err_frame.
module dfp_rx #(
  parameter int CLK_FREQ     = 100_000_000,
  parameter int BAUD         = 9600,
  parameter int CLKS_PER_BIT = CLK_FREQ / BAUD,
  parameter int TIMEOUT_BITS = 40
) (
  input  logic     clk,
  input  logic     reset,
  dfp_rx_if.master bus
);

  localparam int                CNT_W          = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CNT_W-1:0]  BIT_LAST       = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  HALF_LAST      = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam int                TIMEOUT_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;
  localparam int                GAP_W          = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [GAP_W-1:0]  GAP_LAST       = GAP_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bit_state_t;

  typedef enum logic [3:0] {
    P_IDLE, P_VER, P_LEN, P_CMD, P_FBK, P_P1, P_P2, P_CKH, P_CKL, P_END
  } frame_state_t;

  // ---------------------------------------------------------------------------
  // Input synchroniser: [0],[1] form the two-flop synchroniser, [2] is history.
  // ---------------------------------------------------------------------------
  logic [2:0] sync_q;
  logic       rxd;
  logic       rxd_fall;

  assign rxd      = sync_q[1];
  assign rxd_fall = sync_q[2] & ~sync_q[1];

  // Shift the asynchronous line into the clock domain.
  always_ff @(posedge clk) begin
    // NOTE: the synchroniser resets to 1s (line idle) so that leaving reset never looks like a start-bit edge.
    if (!reset) begin
      sync_q <= 3'b111;
    end else begin
      sync_q <= {sync_q[1:0], bus.uart_rxd};
    end
  end

  // ---------------------------------------------------------------------------
  // Bit FSM: start-bit validation, 8 data bits LSB first, stop-bit check.
  // ---------------------------------------------------------------------------
  bit_state_t       b_state;
  logic [CNT_W-1:0] clk_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;
  logic             bit_tick;
  logic             byte_done;
  logic             stop_err;

  assign bit_tick  = (clk_cnt == BIT_LAST);
  // NOTE: byte_done and stop_err decode the stop sample combinationally.
  // The frame FSM therefore acts in that same cycle, and its registered
  // outputs appear exactly one clock after the stop sample.
  assign byte_done = (b_state == B_STOP) && bit_tick && rxd;
  assign stop_err  = (b_state == B_STOP) && bit_tick && !rxd;

  // Sample each bit at its centre.
  // B_IDLE is re-entered on the stop sample so a following start bit is caught.
  always_ff @(posedge clk) begin
    // NOTE: all state here updates with <= so every register sees the pre-edge values, as the hardware does.
    if (!reset) begin
      b_state <= B_IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
    end else begin
      case (b_state)
        B_IDLE: begin
          clk_cnt <= '0;
          if (rxd_fall) b_state <= B_START;
        end
        B_START: begin
          if (clk_cnt == HALF_LAST) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            b_state <= rxd ? B_IDLE : B_DATA;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        B_DATA: begin
          if (bit_tick) begin
            clk_cnt <= '0;
            shift   <= {rxd, shift[7:1]};
            bit_idx <= bit_idx + 1'b1;
            if (bit_idx == 3'd7) b_state <= B_STOP;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        B_STOP: begin
          if (bit_tick) begin
            clk_cnt <= '0;
            b_state <= B_IDLE;
          end else begin
            clk_cnt <= clk_cnt + 1'b1;
          end
        end
        default: b_state <= B_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM: header/tail checks, field capture, running checksum, timeout.
  // ---------------------------------------------------------------------------
  frame_state_t     p_state;
  logic [15:0]      sum;
  logic [7:0]       cmd_q;
  logic [7:0]       p1_q;
  logic [7:0]       p2_q;
  logic [7:0]       ckh_q;
  logic [7:0]       ckl_q;
  logic [GAP_W-1:0] gap_cnt;
  logic [15:0]      cksum_total;
  logic             resync;

  logic             rx_valid_q;
  logic             play_done_q;
  logic             err_cksum_q;
  logic             err_frame_q;
  logic [7:0]       rx_cmd_q;
  logic [15:0]      rx_param_q;

  // The frame is good when the byte sum plus the checksum field wraps to zero.
  assign cksum_total = sum + {ckh_q, ckl_q};
  // A bad header or tail byte that is itself 0x7E may start the next frame.
  assign resync      = (shift == 8'h7E);

  // Advance once per received byte. All status outputs are one-cycle registered pulses.
  always_ff @(posedge clk) begin
    if (!reset) begin
      p_state     <= P_IDLE;
      sum         <= '0;
      cmd_q       <= '0;
      p1_q        <= '0;
      p2_q        <= '0;
      ckh_q       <= '0;
      ckl_q       <= '0;
      gap_cnt     <= '0;
      rx_valid_q  <= 1'b0;
      play_done_q <= 1'b0;
      err_cksum_q <= 1'b0;
      err_frame_q <= 1'b0;
      rx_cmd_q    <= '0;
      rx_param_q  <= '0;
    end else begin
      rx_valid_q  <= 1'b0;
      play_done_q <= 1'b0;
      err_cksum_q <= 1'b0;
      err_frame_q <= 1'b0;

      if (byte_done || p_state == P_IDLE) begin
        gap_cnt <= '0;
      end else begin
        gap_cnt <= gap_cnt + 1'b1;
      end

      if (stop_err) begin
        err_frame_q <= 1'b1;
        p_state     <= P_IDLE;
      end else if (byte_done) begin
        case (p_state)
          P_IDLE: if (shift == 8'h7E) p_state <= P_VER;
          P_VER: begin
            if (shift == 8'hFF) begin
              sum     <= 16'h00FF;
              p_state <= P_LEN;
            end else begin
              err_frame_q <= 1'b1;
              p_state     <= resync ? P_VER : P_IDLE;
            end
          end
          P_LEN: begin
            if (shift == 8'h06) begin
              sum     <= sum + {8'h00, shift};
              p_state <= P_CMD;
            end else begin
              err_frame_q <= 1'b1;
              p_state     <= resync ? P_VER : P_IDLE;
            end
          end
          P_CMD: begin
            cmd_q   <= shift;
            sum     <= sum + {8'h00, shift};
            p_state <= P_FBK;
          end
          P_FBK: begin
            sum     <= sum + {8'h00, shift};
            p_state <= P_P1;
          end
          P_P1: begin
            p1_q    <= shift;
            sum     <= sum + {8'h00, shift};
            p_state <= P_P2;
          end
          P_P2: begin
            p2_q    <= shift;
            sum     <= sum + {8'h00, shift};
            p_state <= P_CKH;
          end
          P_CKH: begin
            ckh_q   <= shift;
            p_state <= P_CKL;
          end
          P_CKL: begin
            ckl_q   <= shift;
            p_state <= P_END;
          end
          P_END: begin
            if (shift == 8'hEF) begin
              if (cksum_total == 16'h0000) begin
                rx_valid_q  <= 1'b1;
                play_done_q <= (cmd_q == 8'h3D) || (cmd_q == 8'h3C);
                rx_cmd_q    <= cmd_q;
                rx_param_q  <= {p1_q, p2_q};
              end else begin
                err_cksum_q <= 1'b1;
              end
              p_state <= P_IDLE;
            end else begin
              err_frame_q <= 1'b1;
              p_state     <= resync ? P_VER : P_IDLE;
            end
          end
          default: p_state <= P_IDLE;
        endcase
      end else if (p_state != P_IDLE && gap_cnt == GAP_LAST) begin
        err_frame_q <= 1'b1;
        p_state     <= P_IDLE;
      end
    end
  end

  assign bus.rx_valid  = rx_valid_q;
  assign bus.play_done = play_done_q;
  assign bus.err_cksum = err_cksum_q;
  assign bus.err_frame = err_frame_q;
  assign bus.rx_cmd    = rx_cmd_q;
  assign bus.rx_param  = rx_param_q;
  assign bus.busy      = (p_state != P_IDLE);

endmodule
